tx_chan_ram_arbiter: RTL
========================

Name: tx_chan_ram_arbiter

Overview:
- Packet-granular read-access scheduler for the transmit packet RAMs.
- Sits between the per-channel packet RAMs' packet-waiting flags and the readers: the data-channel readers and the command reader.
- Grants exactly one requester at a time for a whole packet, then releases the grant after that requester's done pulse, or forcibly after a hold timeout.
- Round-robin among data channels; the command requester optionally takes strict priority.

Parameters:
- NUM_REQ, 3, number of requesters; indices 0..NUM_REQ-2 are data channels, index NUM_REQ-1 is the command channel.
- IDX_W, 2, width of grant_idx; must satisfy 2**IDX_W >= NUM_REQ.
- CMD_PRIORITY, 1, 1 = command requester wins whenever requesting; 0 = command joins the round-robin.
- MAX_HOLD, 16'd1024, maximum cycles a grant may be held before forced release; legal range 2..65535.

Ports:
- txclk  in  1  transmit-domain clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester packet-waiting level.
- done  in  NUM_REQ  per-requester one-cycle packet-finished pulse (RD_done/skip).
- grant  out  NUM_REQ  one-hot grant vector, registered.
- grant_valid  out  1  high while any grant is asserted (OR of grant).
- grant_idx  out  IDX_W  binary index of current holder; 0 when no grant.
- timeout  out  1  one-cycle pulse on forced release.
- timeout_cnt  out  8  saturating count of forced releases.
- cstate  out  2  FSM state, for debug bus.

Behaviour:
- Reset (synchronous, overrides everything including a mid-packet grant):
  - FSM goes to IDLE.
  - grant=0, grant_valid=0, grant_idx=0, timeout=0, timeout_cnt=0.
  - hold counter=0.
  - rr_ptr=NUM_REQ-1, so the first round-robin search starts at index 0.
  - The holder is not notified on reset; the readers are reset by the same signal.
- States (cstate encoding): IDLE=0, GRANT=1, RELEASE=2. Code 3 is unused; it must return to IDLE on the next cycle with grant=0.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select a winner, register it into grant/grant_idx and go to GRANT. Grant appears exactly 1 cycle after req is sampled high.
  - Winner selection:
    - If CMD_PRIORITY=1 and req[NUM_REQ-1]=1, the command requester wins.
    - Otherwise, search indices rr_ptr+1, rr_ptr+2, … modulo NUM_REQ and take the first set req bit. When CMD_PRIORITY=1 the search covers data indices only.
  - rr_ptr is updated to the winner only for round-robin wins. Command-priority wins leave rr_ptr untouched, so fairness among data channels is preserved.
  - The hold counter is cleared on entry to GRANT.
- GRANT:
  - grant holds constant. The holder's req dropping does not release the grant.
  - The hold counter increments each cycle.
  - If done[grant_idx]=1: go to RELEASE; timeout stays 0.
  - Else, if the hold counter reaches MAX_HOLD-1:
    - go to RELEASE;
    - timeout=1 for exactly 1 cycle;
    - timeout_cnt increments, saturating at 255.
  - done bits of non-holders are ignored in every state, and done sampled in IDLE or RELEASE is ignored.
- RELEASE:
  - grant=0 for exactly 1 cycle (gap for RAM read-pointer settle), then go to IDLE.
  - Minimum spacing between grants is therefore 2 idle cycles after the done cycle: done at cycle t → grant low at t+1 → IDLE at t+2 → next grant at t+3.
- Simultaneous events:
  - done and timeout in the same cycle: treat as done; no timeout pulse, counter unchanged.
  - reset together with anything: reset wins.
- Invariants:
  - grant is always zero or one-hot.
  - grant_idx always matches grant.
  - Any requester that holds req continuously is granted within (NUM_REQ)*(MAX_HOLD+2) cycles when CMD_PRIORITY=0.

Test Plan:
- Reset, then req=3'b001 at cycle 0 → grant=3'b001 and grant_idx=0 at cycle 1; done[0] pulse at cycle 5 → grant=0 at cycle 6, cstate=RELEASE; cstate=IDLE at cycle 7.
- req=3'b011 held, each grant ended by done 4 cycles after grant → grant sequence 001, 010, 001, 010; every gap between grants is 2 cycles.
- CMD_PRIORITY=1, req=3'b111 held with prompt done:
  - command (100) wins every arbitration while req[2]=1;
  - drop req[2] → data channel 0 granted first, then channel 1 (rr_ptr unchanged by command wins).
- MAX_HOLD=8, req=3'b010, no done → timeout pulses 8 cycles after grant (hold counter 0..7), grant drops the next cycle, timeout_cnt=1; repeat 300 times → timeout_cnt=255.
- During GRANT to index 0, pulse done[1] and drop req[0] → grant stays 3'b001; assert reset mid-grant → grant=0, cstate=IDLE on the next edge; next req=3'b011 → index 0 is granted first.
- done and timeout coincide (done on the last hold cycle) → RELEASE entered, timeout=0, timeout_cnt unchanged.

Source files
------------

// File: rtl/tx_chan_ram_arbiter.sv
// tx_chan_ram_arbiter: packet-granular read scheduler for the TX packet RAMs.
// One requester owns the RAM read path per packet; released on done or hold timeout.
module tx_chan_ram_arbiter #(
    parameter int          NUM_REQ      = 3,
    parameter int          IDX_W        = 2,
    parameter bit          CMD_PRIORITY = 1'b1,
    parameter logic [15:0] MAX_HOLD     = 16'd1024
) (
    input  logic               txclk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               timeout,
    output logic [7:0]         timeout_cnt,
    output logic [1:0]         cstate
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_REL   = 2'd2;

    localparam logic [IDX_W-1:0] CMD_IDX = IDX_W'(NUM_REQ - 1);

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [15:0]        hold_q, hold_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic               tmo_q, tmo_d;
    logic [7:0]         tcnt_q, tcnt_d;

    logic [NUM_REQ-1:0] req_m;
    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   rr_win;
    logic               rr_found;
    logic               cmd_win;

    // With command priority the round-robin ring only spans the data channels.
    always_comb begin
        req_m    = req;
        if (CMD_PRIORITY) begin
            req_m[NUM_REQ-1] = 1'b0;
        end
        cand     = '0;
        rr_win   = '0;
        rr_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_q) + k) % NUM_REQ);
            if (!rr_found && req_m[cand]) begin
                rr_found = 1'b1;
                rr_win   = cand;
            end
        end
        cmd_win = CMD_PRIORITY && req[NUM_REQ-1];
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        rr_d    = rr_q;
        tmo_d   = 1'b0;
        tcnt_d  = tcnt_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_GRANT;
                    hold_d  = '0;
                    if (cmd_win) begin
                        idx_d = CMD_IDX;
                    end else begin
                        idx_d = rr_win;
                        rr_d  = rr_win;
                    end
                    grant_d = NUM_REQ'(1) << idx_d;
                end
            end
            S_GRANT: begin
                // done beats a timeout landing on the same cycle
                if (|(done & grant_q)) begin
                    state_d = S_REL;
                    grant_d = '0;
                    idx_d   = '0;
                end else if (hold_q == MAX_HOLD - 16'd1) begin
                    state_d = S_REL;
                    grant_d = '0;
                    idx_d   = '0;
                    tmo_d   = 1'b1;
                    if (tcnt_q != 8'hFF) begin
                        tcnt_d = tcnt_q + 8'd1;
                    end
                end else begin
                    hold_d = hold_q + 16'd1;
                end
            end
            S_REL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge txclk) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            rr_q    <= CMD_IDX;
            tmo_q   <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            rr_q    <= rr_d;
            tmo_q   <= tmo_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign grant_idx   = idx_q;
    assign timeout     = tmo_q;
    assign timeout_cnt = tcnt_q;
    assign cstate      = state_q;

endmodule
